tl_a_channel_queue: RTL
=======================

// Module: tl_a_channel_queue
// PURPOSE
//  Decoupled FIFO for one TileLink A-channel beat stream (opcode/param/size/source/address/mask/data/corrupt).
//  Sits directly upstream of the A-channel pass-through port wrapper.
//  Breaks the ready/valid timing path between the master and that wrapper.
//  Absorbs DEPTH beats of back-pressure.
// PARAMETERS
//  DEPTH     2   number of entries; power of two, >= 2
//  SOURCE_W  3   width of source ID field
//  ADDR_W    32  width of address field
//  DATA_W    64  data width; mask width is DATA_W/8
//  FLOW      0   1: an empty queue forwards enq to deq combinationally in the same cycle
// PORTS
//  clock         in   1           rising-edge clock
//  reset         in   1           asynchronous, active-high reset
//  enq_valid     in   1           upstream beat valid
//  enq_ready     out  1           queue can accept a beat
//  enq_opcode    in   3           A opcode
//  enq_param     in   3           A param
//  enq_size      in   3           log2 transfer size
//  enq_source    in   SOURCE_W    source ID
//  enq_address   in   ADDR_W      byte address
//  enq_mask      in   DATA_W/8    byte lane mask
//  enq_data      in   DATA_W      write data
//  enq_corrupt   in   1           data corrupt flag
//  deq_valid     out  1           head beat valid toward wrapper
//  deq_ready     in   1           wrapper accepts head beat
//  deq_opcode..deq_corrupt  out  (same widths as enq_*)  head beat fields
//  count         out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Storage: DEPTH-entry array, write pointer wp, read pointer rp.
//    Each pointer is clog2(DEPTH) bits and wraps modulo DEPTH.
//  - maybe_full flag disambiguates wp==rp.
//    empty = (wp==rp)&!maybe_full; full = (wp==rp)&maybe_full.
//  - Reset (async assert, sync-released by the system):
//    wp=rp=0, maybe_full=0, all storage entries 0.
//  - During reset: enq_ready=0, deq_valid=0, count=0, all deq_* field outputs=0.
//  - Handshakes: enq fire = enq_valid&enq_ready; deq fire = deq_valid&deq_ready.
//  - enq_ready = !full & !reset. Not dependent on deq_ready; no same-cycle pass-through when full.
//  - deq_valid = !empty, or (FLOW & enq_valid) when empty.
//  - deq_* fields = entry[rp]. When FLOW and empty, deq_* = enq_* instead.
//  - Latency: FLOW=0 -> a beat written at edge N is visible on deq in cycle N+1. FLOW=1 -> 0 cycles when empty.
//  - Write on enq fire, except FLOW & empty & deq fire (bypass: nothing stored, pointers unchanged).
//  - On write: entry[wp] <= enq fields; wp <= wp+1.
//  - On deq fire (non-bypass): rp <= rp+1.
//  - maybe_full update:
//    - set when write & !read
//    - cleared when read & !write
//    - unchanged when both or neither
//  - Simultaneous enq+deq with 0<count<DEPTH: count unchanged, both pointers advance.
//  - Full: enq_valid ignored (enq_ready=0); deq fire alone frees one slot, enq_ready=1 next cycle.
//  - Empty, FLOW=0: deq_valid=0 regardless of deq_ready; enq fire stores only.
//  - count = maybe_full&(wp==rp) ? DEPTH : (wp-rp) mod DEPTH.
//  - Beats leave in arrival order; fields are never modified or reordered.
//  - deq_* stable while deq_valid & !deq_ready (FLOW=0, or FLOW=1 with non-empty queue).
//  - Reset mid-operation: all stored beats discarded, state returns to reset values immediately (async).
//    No beat is presented after reset deasserts until a new enq fire.
// TESTING
//  - Reset then idle: count=0, deq_valid=0, deq_data=0.
//    Release reset -> enq_ready=1 next cycle, deq_valid stays 0.
//  - DEPTH=2, FLOW=0: enq opcode=4, addr=0x8000_0000, data=0x1122334455667788, mask=0xFF with deq_ready=0.
//    -> deq_valid=1 next cycle with identical fields, count=1.
//  - Fill 2 beats (source 1,2) with deq_ready=0 -> count=2, enq_ready=0.
//    Third enq_valid held -> not accepted. Then deq_ready=1 -> source 1, then 2, then the third beat.
//  - Steady streaming, enq_valid=deq_ready=1 for 16 beats (address +8 each):
//    -> one beat per cycle, count constant at 1, in-order, corrupt bit preserved.
//  - FLOW=1, empty, enq_valid=1, deq_ready=1 -> deq shows enq fields the same cycle.
//    count stays 0 and no entry is written.
//  - Assert reset while count=2 -> count=0, deq_valid=0 immediately (before the next edge).
//    After release, deq_valid stays 0 until a new enq.

Source files
------------

// File: rtl/tl_a_channel_queue.sv
// rtl/tl_a_channel_queue.sv - decoupling FIFO for one TileLink A-channel beat stream
module tl_a_channel_queue #(
  parameter int DEPTH    = 2,
  parameter int SOURCE_W = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int FLOW     = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [2:0]                 enq_opcode,
  input  logic [2:0]                 enq_param,
  input  logic [2:0]                 enq_size,
  input  logic [SOURCE_W-1:0]        enq_source,
  input  logic [ADDR_W-1:0]          enq_address,
  input  logic [DATA_W/8-1:0]        enq_mask,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       enq_corrupt,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [2:0]                 deq_opcode,
  output logic [2:0]                 deq_param,
  output logic [2:0]                 deq_size,
  output logic [SOURCE_W-1:0]        deq_source,
  output logic [ADDR_W-1:0]          deq_address,
  output logic [DATA_W/8-1:0]        deq_mask,
  output logic [DATA_W-1:0]          deq_data,
  output logic                       deq_corrupt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int MASK_W  = DATA_W / 8;
  localparam int ENTRY_W = 3 + 3 + 3 + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];
  localparam logic           FLOW_EN    = (FLOW != 0);

  // Whole beat is stored as one packed word so fields cannot drift apart.
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rp;
  logic               maybe_full;

  logic               ptr_match;
  logic               empty;
  logic               full;
  logic               bypass;
  logic               do_write;
  logic               do_read;
  logic [ENTRY_W-1:0] enq_word;
  logic [ENTRY_W-1:0] out_word;

  assign enq_word = {enq_opcode, enq_param, enq_size, enq_source,
                     enq_address, enq_mask, enq_data, enq_corrupt};

  assign ptr_match = (wp == rp);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  // Ready never looks at deq_ready, which is what breaks the timing path.
  assign enq_ready = ~full & ~reset;
  assign deq_valid = ~reset & (~empty | (FLOW_EN & enq_valid));

  // With flow-through on an empty queue the beat passes straight across and is never stored.
  assign bypass   = FLOW_EN & empty & enq_valid & deq_ready & ~reset;
  assign do_write = enq_valid & enq_ready & ~bypass;
  assign do_read  = deq_ready & ~empty & ~reset;

  // Outputs are forced to zero while reset is held, even on the flow-through path.
  assign out_word = reset ? '0 : ((FLOW_EN & empty) ? enq_word : mem[rp]);

  assign {deq_opcode, deq_param, deq_size, deq_source,
          deq_address, deq_mask, deq_data, deq_corrupt} = out_word;

  assign count = full ? FULL_COUNT : {1'b0, PTR_W'(wp - rp)};

  // Entry storage: cleared on reset, written at the write pointer on an accepted beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[wp] <= enq_word;
    end
  end

  // Pointer and full/empty disambiguation state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_write) begin
        wp <= wp + PTR_W'(1);
      end
      if (do_read) begin
        rp <= rp + PTR_W'(1);
      end
      if (do_write != do_read) begin
        maybe_full <= do_write;
      end
    end
  end

endmodule
